uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and parameter defaults.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;
    localparam int PARITY_EN_DEF  = 1;
    localparam int PARITY_ODD_DEF = 0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        RECOVER
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, mid-bit sampling, parity/stop checks; SIPO shift/load strobes.
// IDLE wait start | START verify mid-bit | DATA sample bits | PARITY check | STOP verdict | RECOVER wait line high
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int PARITY_EN  = PARITY_EN_DEF,
    parameter int PARITY_ODD = PARITY_ODD_DEF
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic rx_en,
    input  logic baud_tick,
    input  logic serial_data_in,
    output logic shift,
    output logic sample_bit,
    output logic load,
    output logic busy,
    output logic data_valid,
    output logic parity_err,
    output logic frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          ODD_BIT   = 1'(PARITY_ODD);

    logic            rxs;
    rx_state_t       state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            xor_q, xor_d;
    logic            mis_q, mis_d;
    logic            shift_q, shift_d;
    logic            sample_q, sample_d;
    logic            load_q, load_d;
    logic            busy_q, busy_d;
    logic            dv_q, dv_d;
    logic            pe_q, pe_d;
    logic            fe_q, fe_d;
    logic            wrap;

    sync_2ff u_sync (
        .clk_i (sys_clk),
        .rst_i (rst),
        .d_i   (serial_data_in),
        .q_o   (rxs)
    );

    assign wrap = baud_tick && (tick_q == TICK_LAST);

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        xor_d    = xor_q;
        mis_d    = mis_q;
        shift_d  = 1'b0;
        sample_d = 1'b0;
        load_d   = 1'b0;
        dv_d     = 1'b0;
        pe_d     = 1'b0;
        fe_d     = 1'b0;

        // Disabling wins over everything, including a frame finishing this cycle.
        if (!rx_en) begin
            state_d = IDLE;
            tick_d  = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (baud_tick && !rxs) begin
                        state_d = START;
                        tick_d  = '0;
                        xor_d   = 1'b0;
                        mis_d   = 1'b0;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        if (tick_q == TICK_MID) begin
                            tick_d  = '0;
                            bit_d   = '0;
                            state_d = rxs ? IDLE : DATA;
                        end else begin
                            tick_d = tick_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (wrap) begin
                        tick_d   = '0;
                        shift_d  = 1'b1;
                        sample_d = rxs;
                        xor_d    = xor_q ^ rxs;
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else if (baud_tick) begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (wrap) begin
                        tick_d  = '0;
                        mis_d   = xor_q ^ rxs ^ ODD_BIT;
                        state_d = STOP;
                    end else if (baud_tick) begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (wrap) begin
                        tick_d = '0;
                        load_d = 1'b1;
                        pe_d   = mis_q;
                        if (rxs) begin
                            dv_d    = !mis_q;
                            state_d = IDLE;
                        end else begin
                            fe_d    = 1'b1;
                            state_d = RECOVER;
                        end
                    end else if (baud_tick) begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                RECOVER: begin
                    if (baud_tick && rxs) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            xor_q    <= 1'b0;
            mis_q    <= 1'b0;
            shift_q  <= 1'b0;
            sample_q <= 1'b0;
            load_q   <= 1'b0;
            busy_q   <= 1'b0;
            dv_q     <= 1'b0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            xor_q    <= xor_d;
            mis_q    <= mis_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            load_q   <= load_d;
            busy_q   <= busy_d;
            dv_q     <= dv_d;
            pe_q     <= pe_d;
            fe_q     <= fe_d;
        end
    end

    assign shift      = shift_q;
    assign sample_bit = sample_q;
    assign load       = load_q;
    assign busy       = busy_q;
    assign data_valid = dv_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;

endmodule
